// File: rtl/instr_encode_loader.sv
// instr_encode_loader: packs field-level instruction commands into RV32I/vector words and writes them sequentially to imem
// Ports: clk_i/rst_i (sync active-high); start_i+base_addr_i begin a load; cmd_* is the valid/ready command stream;
// imem_req_o/imem_gnt_i/imem_addr_o/imem_wdata_o is the write port; busy_o, done_o, err_o and wrap_o report status.
// Optional macro ENCODER_NOP_PAD_EN appends PAD_COUNT addi x0,x0,0 words after the last command.
module instr_encode_loader #(
  parameter int ADDR_W    = 10,
  parameter int PAD_COUNT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_class_i,
  input  logic              cmd_last_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [11:0]       imm_i,
  output logic              imem_req_o,
  input  logic              imem_gnt_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              wrap_o
);
  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
`ifdef ENCODER_NOP_PAD_EN
    PAD,
`endif
    DONE
  } state_t;
  state_t state_q, state_d;
  logic req_q, req_d, err_q, err_d, wrap_q, wrap_d;
  logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d, enc;
  logic [12:0] off;
  logic slot, accept, legal, pad_issue;
`ifdef ENCODER_NOP_PAD_EN
  logic [15:0] pad_q, pad_d;
`else
  logic [31:0] unused_pad;
  assign unused_pad = PAD_COUNT;
`endif
  // the single output slot can take a new word when empty or being drained this cycle
  assign slot        = !req_q || imem_gnt_i;
  assign cmd_ready_o = (state_q == RUN) && slot;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign legal       = cmd_class_i < 3'd6;
  assign off         = {imm_i, 1'b0};
  always_comb
    enc = cmd_class_i == 3'd0 ? {imm_i, rs1_i, funct3_i, rd_i, 7'b0010011} :
          cmd_class_i == 3'd1 ? {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, 7'b0110011} :
          cmd_class_i == 3'd2 ? {off[12], off[10:5], rs2_i, rs1_i, funct3_i, off[4:1], off[11], 7'b1100011} :
          cmd_class_i == 3'd3 ? {imm_i, rs1_i, 3'b010, rd_i, 7'b0000011} :
          cmd_class_i == 3'd4 ? {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], 7'b0100011} :
                                {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, 7'b1010111};
  always_comb begin
    state_d   = state_q;
    req_d     = req_q && !imem_gnt_i;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    wrap_d    = wrap_q || (req_q && imem_gnt_i && &addr_q);
    pad_issue = 1'b0;
`ifdef ENCODER_NOP_PAD_EN
    pad_d     = pad_q;
`endif
    case (state_q)
      IDLE: if (start_i) begin
        state_d = RUN;
        cnt_d   = base_addr_i;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
      end
      RUN: if (accept) begin
        err_d   = err_q || !legal;
        state_d = cmd_last_i ? DRAIN : RUN;
      end
`ifdef ENCODER_NOP_PAD_EN
      DRAIN: if (slot) begin
        state_d = (PAD_COUNT == 0) ? DONE : PAD;
        pad_d   = 16'(PAD_COUNT);
      end
      PAD: if (slot) begin
        pad_issue = pad_q != 16'd0;
        pad_d     = pad_issue ? pad_q - 16'd1 : pad_q;
        state_d   = pad_issue ? PAD : DONE;
      end
`else
      DRAIN: state_d = slot ? DONE : DRAIN;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // illegal classes are consumed without a write, so the address stays contiguous
    if ((accept && legal) || pad_issue) begin
      req_d   = 1'b1;
      addr_d  = cnt_q;
      wdata_d = pad_issue ? 32'h0000_0013 : enc;
      cnt_d   = cnt_q + ADDR_W'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef ENCODER_NOP_PAD_EN
      pad_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
`ifdef ENCODER_NOP_PAD_EN
      pad_q   <= pad_d;
`endif
    end
  end
  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign busy_o       = state_q != IDLE;
  assign done_o       = state_q == DONE;
  assign err_o        = err_q;
  assign wrap_o       = wrap_q;
endmodule
